// File: rtl/acc_feed.sv
// acc_feed: input sequencer for the four-channel output accumulator.
//
// Takes a valid/ready word stream and deals words round-robin onto channels 0..3,
// wrapping each job in the accumulator control sequence:
//   CLEAR -> FEED (cfg_len words per channel) -> DRAIN -> STOP -> SUM -> TSTOP
//
// Ports:
//   clk, rst                    clock; asynchronous active-low reset
//   start, cfg_len              job start pulse (IDLE only); words per channel
//   in_valid, in_data, in_ready input stream handshake
//   sig                         accumulator code: 001 accumulate, 010 sum channels, 000 idle
//   data0..3, valid0..3         per-channel data (held) and one-cycle strobes
//   clear0..3, clear_total      accumulator clear pulses
//   stop0..3, stop_total        final-result pulses
//   busy, done                  job in progress; one-cycle end-of-job pulse
//
// Every output is a register. Each one is loaded from the next state, so it changes
// on the same edge as the state it belongs to.
module acc_feed #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [2:0]        sig,
    output logic [DATA_W-1:0] data0,
    output logic [DATA_W-1:0] data1,
    output logic [DATA_W-1:0] data2,
    output logic [DATA_W-1:0] data3,
    output logic              valid0,
    output logic              valid1,
    output logic              valid2,
    output logic              valid3,
    output logic              clear0,
    output logic              clear1,
    output logic              clear2,
    output logic              clear3,
    output logic              clear_total,
    output logic              stop0,
    output logic              stop1,
    output logic              stop2,
    output logic              stop3,
    output logic              stop_total,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CntW = LEN_W + 2;

    localparam logic [2:0] SigIdle = 3'b000;
    localparam logic [2:0] SigAcc  = 3'b001;
    localparam logic [2:0] SigSum  = 3'b010;

    typedef enum logic [2:0] {
        StIdle, StClear, StFeed, StDrain, StStop, StSum, StTstop
    } state_e;

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [1:0]        ptr_q, ptr_d;
    logic              hs;

    logic              in_ready_q, in_ready_d;
    logic [2:0]        sig_q, sig_d;
    logic [3:0]        valid_q, valid_d;
    logic              clear_q, clear_d;
    logic              stop_q, stop_d;
    logic              tstop_q, tstop_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] data_q [4];

    // in_ready_q is high exactly while the state register holds FEED.
    assign hs = in_ready_q & in_valid;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    len_d   = cfg_len;
                    cnt_d   = '0;
                    ptr_d   = '0;
                    state_d = StClear;
                end
            end
            StClear: state_d = (len_q != '0) ? StFeed : StDrain;
            StFeed: begin
                if (hs) begin
                    ptr_d = ptr_q + 2'd1;
                    cnt_d = cnt_q + CntW'(1);
                    // Total job length is 4 * len_q words.
                    if (cnt_d == {len_q, 2'b00}) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: state_d = StStop;
            StStop:  state_d = StSum;
            StSum:   state_d = StTstop;
            StTstop: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready_d = (state_d == StFeed);
        clear_d    = (state_d == StClear);
        stop_d     = (state_d == StStop);
        tstop_d    = (state_d == StTstop);
        busy_d     = (state_d != StIdle);
        valid_d    = hs ? (4'b0001 << ptr_q) : 4'b0000;
        sig_d      = SigIdle;
        if (state_d == StFeed || state_d == StDrain || state_d == StStop) begin
            sig_d = SigAcc;
        end else if (state_d == StSum) begin
            sig_d = SigSum;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            len_q      <= '0;
            cnt_q      <= '0;
            ptr_q      <= '0;
            in_ready_q <= 1'b0;
            sig_q      <= SigIdle;
            valid_q    <= '0;
            clear_q    <= 1'b0;
            stop_q     <= 1'b0;
            tstop_q    <= 1'b0;
            busy_q     <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            in_ready_q <= in_ready_d;
            sig_q      <= sig_d;
            valid_q    <= valid_d;
            clear_q    <= clear_d;
            stop_q     <= stop_d;
            tstop_q    <= tstop_d;
            busy_q     <= busy_d;
            if (hs) begin
                data_q[ptr_q] <= in_data;
            end
        end
    end

    assign in_ready    = in_ready_q;
    assign sig         = sig_q;
    assign data0       = data_q[0];
    assign data1       = data_q[1];
    assign data2       = data_q[2];
    assign data3       = data_q[3];
    assign valid0      = valid_q[0];
    assign valid1      = valid_q[1];
    assign valid2      = valid_q[2];
    assign valid3      = valid_q[3];
    assign clear0      = clear_q;
    assign clear1      = clear_q;
    assign clear2      = clear_q;
    assign clear3      = clear_q;
    assign clear_total = clear_q;
    assign stop0       = stop_q;
    assign stop1       = stop_q;
    assign stop2       = stop_q;
    assign stop3       = stop_q;
    assign stop_total  = tstop_q;
    assign done        = tstop_q;
    assign busy        = busy_q;

endmodule
